// File: rtl/fpu_pkg.sv
// Shared FPU constants: opcodes, one-hot bit positions, result-type encodings,
// operand classes and the canonical quiet-NaN pattern.
package fpu_pkg;

    localparam int OPC_ROUND = 1;
    localparam int OPC_CAST  = 2;
    localparam int OPC_ADD   = 3;
    localparam int OPC_SUB   = 4;
    localparam int OPC_MULT  = 5;
    localparam int OPC_DIV   = 6;
    localparam int OPC_COMP  = 7;

    localparam int OP_ROUND_BIT = 0;
    localparam int OP_CAST_BIT  = 1;
    localparam int OP_ADD_BIT   = 2;
    localparam int OP_SUB_BIT   = 3;
    localparam int OP_MULT_BIT  = 4;
    localparam int OP_DIV_BIT   = 5;
    localparam int OP_COMP_BIT  = 6;

    localparam int RT_FINITE_BIT  = 0;
    localparam int RT_INDET_BIT   = 1;
    localparam int RT_NEG_INF_BIT = 2;
    localparam int RT_POS_INF_BIT = 3;
    localparam int RT_NAN_BIT     = 4;

    localparam logic [4:0] RT_FINITE  = 5'b00001;
    localparam logic [4:0] RT_INDET   = 5'b00010;
    localparam logic [4:0] RT_NEG_INF = 5'b00100;
    localparam logic [4:0] RT_POS_INF = 5'b01000;
    localparam logic [4:0] RT_NAN     = 5'b10000;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUBNORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } op_class_e;

    // {0, all-ones exponent, 1, zeros}, right-aligned in a 128-bit container.
    function automatic logic [127:0] canonical_nan(input int exp_w, input int frac_w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[frac_w + i] = 1'b1;
        r[frac_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fpu_dec_q_if.sv
// Streaming handshake and decoded-field bundle between the register front-end,
// the operand decoder queue and the arithmetic units.
interface fpu_dec_q_if #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int FRACTION_WIDTH = 23,
    parameter int OPCODE_WIDTH   = 5,
    parameter int DEPTH          = 2
);
    localparam int OW = 1 + EXPONENT_WIDTH + FRACTION_WIDTH;
    localparam int LW = $clog2(DEPTH + 1);

    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [OPCODE_WIDTH-1:0]   fpu_opcode_i;
    logic [OW-1:0]             fpu_operand1_i;
    logic [OW-1:0]             fpu_operand2_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [6:0]                fpu_op_o;
    logic [4:0]                fpu_res_type_o;
    logic                      fpu_dec_sign1_o;
    logic                      fpu_dec_sign2_o;
    logic [EXPONENT_WIDTH-1:0] fpu_dec_exp1_o;
    logic [EXPONENT_WIDTH-1:0] fpu_dec_exp2_o;
    logic [FRACTION_WIDTH:0]   fpu_dec_sfgnd1_o;
    logic [FRACTION_WIDTH:0]   fpu_dec_sfgnd2_o;
    logic [1:0]                fpu_dec_subnorm_o;
    logic                      fpu_dec_invalid_o;
    logic                      fpu_dec_illegal_o;
    logic [OW-1:0]             fpu_res_nan_o;
    logic [LW-1:0]             fpu_dec_level_o;

    modport slave (
        input  in_valid_i, fpu_opcode_i, fpu_operand1_i, fpu_operand2_i, out_ready_i,
        output in_ready_o, out_valid_o, fpu_op_o, fpu_res_type_o,
               fpu_dec_sign1_o, fpu_dec_sign2_o, fpu_dec_exp1_o, fpu_dec_exp2_o,
               fpu_dec_sfgnd1_o, fpu_dec_sfgnd2_o, fpu_dec_subnorm_o,
               fpu_dec_invalid_o, fpu_dec_illegal_o, fpu_res_nan_o, fpu_dec_level_o
    );

    modport master (
        output in_valid_i, fpu_opcode_i, fpu_operand1_i, fpu_operand2_i, out_ready_i,
        input  in_ready_o, out_valid_o, fpu_op_o, fpu_res_type_o,
               fpu_dec_sign1_o, fpu_dec_sign2_o, fpu_dec_exp1_o, fpu_dec_exp2_o,
               fpu_dec_sfgnd1_o, fpu_dec_sfgnd2_o, fpu_dec_subnorm_o,
               fpu_dec_invalid_o, fpu_dec_illegal_o, fpu_res_nan_o, fpu_dec_level_o
    );

endinterface

// File: rtl/fpu_opclass.sv
// Combinational IEEE-754 operand classifier: class, sign and hidden bit.
module fpu_opclass
    import fpu_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int FRACTION_WIDTH = 23
) (
    input  logic [EXPONENT_WIDTH+FRACTION_WIDTH:0] operand_i,
    output op_class_e                              class_o,
    output logic                                   sign_o,
    output logic                                   hidden_o
);

    logic [EXPONENT_WIDTH-1:0] exp_w;
    logic [FRACTION_WIDTH-1:0] frac_w;

    assign exp_w    = operand_i[FRACTION_WIDTH +: EXPONENT_WIDTH];
    assign frac_w   = operand_i[FRACTION_WIDTH-1:0];
    assign sign_o   = operand_i[EXPONENT_WIDTH+FRACTION_WIDTH];
    assign hidden_o = |exp_w;

    always_comb begin
        // NOTE: default first so every path assigns class_o and no latch is inferred.
        class_o = CLS_NORMAL;
        if (exp_w == '0) begin
            class_o = (frac_w == '0) ? CLS_ZERO : CLS_SUBNORM;
        end else if (&exp_w) begin
            if (frac_w == '0)                class_o = CLS_INF;
            else if (frac_w[FRACTION_WIDTH-1]) class_o = CLS_QNAN;
            else                             class_o = CLS_SNAN;
        end
    end

endmodule

// File: rtl/fpu_dec_q.sv
// FPU operand decoder with special-result prediction, feeding a DEPTH-entry
// output FIFO with valid/ready back-pressure on both sides.
module fpu_dec_q
    import fpu_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int FRACTION_WIDTH = 23,
    parameter int OPCODE_WIDTH   = 5,
    parameter int DEPTH          = 2,
    parameter int NAN_MODE       = 0
) (
    input  logic        fpu_clk,
    input  logic        fpu_rst_n,
    input  logic        fpu_dec_flush_i,
    fpu_dec_q_if.slave  bus
);

    localparam int EW = EXPONENT_WIDTH;
    localparam int FW = FRACTION_WIDTH;
    localparam int OPERAND_WIDTH = 1 + EW + FW;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [127:0]             CANON_FULL = canonical_nan(EW, FW);
    localparam logic [OPERAND_WIDTH-1:0] CANON_NAN  = CANON_FULL[OPERAND_WIDTH-1:0];
    localparam logic [OPERAND_WIDTH-1:0] QUIET_BIT  = {{(EW+1){1'b0}}, 1'b1, {(FW-1){1'b0}}};

    typedef struct packed {
        logic [6:0]               op;
        logic [4:0]               res_type;
        logic                     sign1;
        logic                     sign2;
        logic [EW-1:0]            exp1;
        logic [EW-1:0]            exp2;
        logic [FW:0]              sfgnd1;
        logic [FW:0]              sfgnd2;
        logic [1:0]               subnorm;
        logic                     invalid;
        logic                     illegal;
        logic [OPERAND_WIDTH-1:0] res_nan;
    } entry_t;

    op_class_e cls1, cls2;
    logic      sign1, sign2, hid1, hid2;

    fpu_opclass #(.EXPONENT_WIDTH(EW), .FRACTION_WIDTH(FW)) u_cls1 (
        .operand_i (bus.fpu_operand1_i),
        .class_o   (cls1),
        .sign_o    (sign1),
        .hidden_o  (hid1)
    );

    fpu_opclass #(.EXPONENT_WIDTH(EW), .FRACTION_WIDTH(FW)) u_cls2 (
        .operand_i (bus.fpu_operand2_i),
        .class_o   (cls2),
        .sign_o    (sign2),
        .hidden_o  (hid2)
    );

    entry_t entry_d;
    int     opc;
    logic   illegal, unary, indet, inf_hit, inf_sign;
    logic   inf1, inf2, zero1, zero2, fin1, fin2, snan1, snan2, qnan1, qnan2;

    always_comb begin
        opc      = int'(bus.fpu_opcode_i);
        illegal  = (opc < OPC_ROUND) || (opc > OPC_COMP);
        unary    = (opc == OPC_ROUND) || (opc == OPC_CAST);
        inf1     = (cls1 == CLS_INF);
        zero1    = (cls1 == CLS_ZERO);
        fin1     = (cls1 == CLS_ZERO) || (cls1 == CLS_SUBNORM) || (cls1 == CLS_NORMAL);
        snan1    = (cls1 == CLS_SNAN);
        qnan1    = (cls1 == CLS_QNAN);
        // Operand 2 is invisible to the unary ops.
        inf2     = !unary && (cls2 == CLS_INF);
        zero2    = !unary && (cls2 == CLS_ZERO);
        fin2     = !unary && ((cls2 == CLS_ZERO) || (cls2 == CLS_SUBNORM) || (cls2 == CLS_NORMAL));
        snan2    = !unary && (cls2 == CLS_SNAN);
        qnan2    = !unary && (cls2 == CLS_QNAN);
        indet    = 1'b0;
        inf_hit  = 1'b0;
        inf_sign = 1'b0;

        case (opc)
            OPC_ROUND, OPC_CAST: begin
                inf_hit  = inf1;
                inf_sign = sign1;
            end
            OPC_ADD: begin
                indet    = inf1 && inf2 && (sign1 != sign2);
                inf_hit  = inf1 || inf2;
                inf_sign = inf1 ? sign1 : sign2;
            end
            OPC_SUB: begin
                indet    = inf1 && inf2 && (sign1 == sign2);
                inf_hit  = inf1 || inf2;
                inf_sign = inf1 ? sign1 : !sign2;
            end
            OPC_MULT: begin
                indet    = (zero1 && inf2) || (inf1 && zero2);
                inf_hit  = (inf1 || inf2) && !zero1 && !zero2;
                inf_sign = sign1 ^ sign2;
            end
            OPC_DIV: begin
                indet    = (inf1 && inf2) || (zero1 && zero2);
                inf_hit  = (inf1 && fin2) || (fin1 && !zero1 && zero2);
                inf_sign = sign1 ^ sign2;
            end
            default: ;
        endcase

        entry_d          = '0;
        entry_d.op       = illegal ? 7'd0 : (7'd1 << (opc - 1));
        entry_d.sign1    = sign1;
        entry_d.sign2    = sign2;
        entry_d.exp1     = bus.fpu_operand1_i[FW +: EW];
        entry_d.exp2     = bus.fpu_operand2_i[FW +: EW];
        entry_d.sfgnd1   = {hid1, bus.fpu_operand1_i[FW-1:0]};
        entry_d.sfgnd2   = {hid2, bus.fpu_operand2_i[FW-1:0]};
        entry_d.subnorm  = {!unary && (cls2 == CLS_SUBNORM), cls1 == CLS_SUBNORM};
        entry_d.illegal  = illegal;

        if (illegal || snan1 || snan2 || qnan1 || qnan2) entry_d.res_type = RT_NAN;
        else if (indet)                                   entry_d.res_type = RT_INDET;
        else if (inf_hit)                                 entry_d.res_type = inf_sign ? RT_NEG_INF : RT_POS_INF;
        else                                              entry_d.res_type = RT_FINITE;

        entry_d.invalid = illegal || snan1 || snan2 || (entry_d.res_type == RT_INDET);

        if (entry_d.res_type == RT_NAN) begin
            if (illegal || NAN_MODE == 1) entry_d.res_nan = CANON_NAN;
            else if (snan1)               entry_d.res_nan = bus.fpu_operand1_i | QUIET_BIT;
            else if (snan2)               entry_d.res_nan = bus.fpu_operand2_i | QUIET_BIT;
            else if (qnan1)               entry_d.res_nan = bus.fpu_operand1_i;
            else                          entry_d.res_nan = bus.fpu_operand2_i;
        end
    end

    // Output FIFO
    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    assign bus.in_ready_o  = (level_q < LW'(DEPTH));
    assign bus.out_valid_o = (level_q != '0);
    assign push = bus.in_valid_i && bus.in_ready_o && !fpu_dec_flush_i;
    assign pop  = bus.out_valid_o && bus.out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (fpu_dec_flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge fpu_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!fpu_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; an empty FIFO masks the head, so stale entries never show.
    always_ff @(posedge fpu_clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

    assign head = bus.out_valid_o ? mem_q[rd_ptr_q] : '0;

    assign bus.fpu_op_o          = head.op;
    assign bus.fpu_res_type_o    = head.res_type;
    assign bus.fpu_dec_sign1_o   = head.sign1;
    assign bus.fpu_dec_sign2_o   = head.sign2;
    assign bus.fpu_dec_exp1_o    = head.exp1;
    assign bus.fpu_dec_exp2_o    = head.exp2;
    assign bus.fpu_dec_sfgnd1_o  = head.sfgnd1;
    assign bus.fpu_dec_sfgnd2_o  = head.sfgnd2;
    assign bus.fpu_dec_subnorm_o = head.subnorm;
    assign bus.fpu_dec_invalid_o = head.invalid;
    assign bus.fpu_dec_illegal_o = head.illegal;
    assign bus.fpu_res_nan_o     = head.res_nan;
    assign bus.fpu_dec_level_o   = level_q;

endmodule

// File: tb/tb_fpu_dec_q.sv
// Directed bench for fpu_dec_q: decode cases on a NAN_MODE=0 and a NAN_MODE=1
// instance driven in lockstep, plus FIFO back-pressure, flush and reset.
module tb_fpu_dec_q;

    logic fpu_clk = 1'b0;
    logic fpu_rst_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 fpu_clk = ~fpu_clk;

    fpu_dec_q_if #(.EXPONENT_WIDTH(8), .FRACTION_WIDTH(23), .OPCODE_WIDTH(5), .DEPTH(2)) b0 ();
    fpu_dec_q_if #(.EXPONENT_WIDTH(8), .FRACTION_WIDTH(23), .OPCODE_WIDTH(5), .DEPTH(2)) b1 ();

    fpu_dec_q #(.DEPTH(2), .NAN_MODE(0)) u_dut0 (
        .fpu_clk         (fpu_clk),
        .fpu_rst_n       (fpu_rst_n),
        .fpu_dec_flush_i (flush),
        .bus             (b0.slave)
    );

    fpu_dec_q #(.DEPTH(2), .NAN_MODE(1)) u_dut1 (
        .fpu_clk         (fpu_clk),
        .fpu_rst_n       (fpu_rst_n),
        .fpu_dec_flush_i (flush),
        .bus             (b1.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpu_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        b0.in_valid_i = v;     b1.in_valid_i = v;
        b0.fpu_opcode_i = opc; b1.fpu_opcode_i = opc;
        b0.fpu_operand1_i = a; b1.fpu_operand1_i = a;
        b0.fpu_operand2_i = b; b1.fpu_operand2_i = b;
    endtask

    task automatic set_ready(input logic r);
        b0.out_ready_i = r;
        b1.out_ready_i = r;
    endtask

    // Push one beat into an empty queue and leave it at the head.
    task automatic send(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        set_ready(1'b0);
        drive(1'b1, opc, a, b);
        tick();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic drain();
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        check("drain_level", 64'(b0.fpu_dec_level_o), 64'd0);
    endtask

    initial begin
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        set_ready(1'b0);
        repeat (3) tick();
        check("rst_valid", 64'(b0.out_valid_o), 64'd0);
        check("rst_level", 64'(b0.fpu_dec_level_o), 64'd0);
        check("rst_res", 64'(b0.fpu_res_type_o), 64'd0);
        fpu_rst_n = 1'b1;
        tick();
        check("rst_ready", 64'(b0.in_ready_o), 64'd1);

        // ADD +inf + -inf: indeterminate, visible one cycle after acceptance
        set_ready(1'b0);
        drive(1'b1, 5'd3, 32'h7F800000, 32'hFF800000);
        check("add_pre_valid", 64'(b0.out_valid_o), 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        check("add_valid", 64'(b0.out_valid_o), 64'd1);
        check("add_res", 64'(b0.fpu_res_type_o), 64'b00010);
        check("add_inv", 64'(b0.fpu_dec_invalid_o), 64'd1);
        check("add_op", 64'(b0.fpu_op_o), 64'b0000100);
        check("add_level", 64'(b0.fpu_dec_level_o), 64'd1);
        drain();

        send(5'd5, 32'hFF800000, 32'hC0000000);
        check("mul_res", 64'(b0.fpu_res_type_o), 64'b01000);
        check("mul_inv", 64'(b0.fpu_dec_invalid_o), 64'd0);
        check("mul_op", 64'(b0.fpu_op_o), 64'b0010000);
        check("mul_sign1", 64'(b0.fpu_dec_sign1_o), 64'd1);
        check("mul_exp1", 64'(b0.fpu_dec_exp1_o), 64'hFF);
        check("mul_sfgnd1", 64'(b0.fpu_dec_sfgnd1_o), 64'h800000);
        drain();

        send(5'd6, 32'h3F800000, 32'h80000000);
        check("div_res", 64'(b0.fpu_res_type_o), 64'b00100);
        check("div_exp1", 64'(b0.fpu_dec_exp1_o), 64'h7F);
        check("div_sfgnd2", 64'(b0.fpu_dec_sfgnd2_o), 64'h0);
        check("div_sign2", 64'(b0.fpu_dec_sign2_o), 64'd1);
        drain();

        send(5'd6, 32'h00000000, 32'h80000000);
        check("div00_res", 64'(b0.fpu_res_type_o), 64'b00010);
        check("div00_inv", 64'(b0.fpu_dec_invalid_o), 64'd1);
        drain();

        send(5'd4, 32'h7F800000, 32'h7F800000);
        check("sub_indet", 64'(b0.fpu_res_type_o), 64'b00010);
        drain();
        send(5'd4, 32'h3F800000, 32'h7F800000);
        check("sub_ninf", 64'(b0.fpu_res_type_o), 64'b00100);
        drain();

        // sNaN then qNaN: quieted operand 1 vs canonical
        send(5'd3, 32'h7F800001, 32'h7FC00005);
        check("nan0_val", 64'(b0.fpu_res_nan_o), 64'h7FC00001);
        check("nan0_res", 64'(b0.fpu_res_type_o), 64'b10000);
        check("nan0_inv", 64'(b0.fpu_dec_invalid_o), 64'd1);
        check("nan1_val", 64'(b1.fpu_res_nan_o), 64'h7FC00000);
        drain();

        send(5'd3, 32'h3F800000, 32'hFFC00007);
        check("qnan2_val", 64'(b0.fpu_res_nan_o), 64'hFFC00007);
        check("qnan2_inv", 64'(b0.fpu_dec_invalid_o), 64'd0);
        drain();

        send(5'd0, 32'h3F800000, 32'h3F800000);
        check("ill_flag", 64'(b0.fpu_dec_illegal_o), 64'd1);
        check("ill_op", 64'(b0.fpu_op_o), 64'd0);
        check("ill_res", 64'(b0.fpu_res_type_o), 64'b10000);
        check("ill_inv", 64'(b0.fpu_dec_invalid_o), 64'd1);
        check("ill_nan", 64'(b0.fpu_res_nan_o), 64'h7FC00000);
        drain();

        send(5'd3, 32'h00000001, 32'h3F800000);
        check("sub_norm", 64'(b0.fpu_dec_subnorm_o), 64'b01);
        check("sub_sfgnd1", 64'(b0.fpu_dec_sfgnd1_o), 64'h000001);
        check("sub_sfgnd2", 64'(b0.fpu_dec_sfgnd2_o), 64'h800000);
        check("sub_res", 64'(b0.fpu_res_type_o), 64'b00001);
        drain();

        // ROUND ignores an sNaN in operand 2
        send(5'd1, 32'h40000000, 32'h7F800001);
        check("rnd_res", 64'(b0.fpu_res_type_o), 64'b00001);
        check("rnd_inv", 64'(b0.fpu_dec_invalid_o), 64'd0);
        check("rnd_nan", 64'(b0.fpu_res_nan_o), 64'h0);
        check("rnd_op", 64'(b0.fpu_op_o), 64'b0000001);
        drain();

        // Back-pressure: three beats offered into a two-entry queue
        set_ready(1'b0);
        drive(1'b1, 5'd3, 32'h3F800000, 32'h3F800000);
        tick();
        check("bp_lvl1", 64'(b0.fpu_dec_level_o), 64'd1);
        drive(1'b1, 5'd5, 32'h7F800000, 32'h40000000);
        tick();
        check("bp_lvl2", 64'(b0.fpu_dec_level_o), 64'd2);
        check("bp_rdy0", 64'(b0.in_ready_o), 64'd0);
        drive(1'b1, 5'd6, 32'h00000000, 32'h00000000);
        tick();
        check("bp_hold_lvl", 64'(b0.fpu_dec_level_o), 64'd2);
        check("bp_hold_head", 64'(b0.fpu_op_o), 64'b0000100);
        check("bp_hold_rdy", 64'(b0.in_ready_o), 64'd0);
        set_ready(1'b1);
        tick();
        check("bp_pop1_lvl", 64'(b0.fpu_dec_level_o), 64'd1);
        check("bp_pop1_head", 64'(b0.fpu_res_type_o), 64'b01000);
        check("bp_pop1_rdy", 64'(b0.in_ready_o), 64'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        check("bp_pop2_lvl", 64'(b0.fpu_dec_level_o), 64'd1);
        check("bp_pop2_head", 64'(b0.fpu_res_type_o), 64'b00010);
        tick();
        check("bp_empty", 64'(b0.out_valid_o), 64'd0);
        check("bp_empty_op", 64'(b0.fpu_op_o), 64'd0);

        // Streaming at one beat per cycle
        begin
            logic [4:0] opcs [4];
            logic [6:0] ops  [4];
            opcs = '{5'd3, 5'd4, 5'd5, 5'd6};
            ops  = '{7'b0000100, 7'b0001000, 7'b0010000, 7'b0100000};
            set_ready(1'b1);
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, opcs[i], 32'h3F800000, 32'h40000000);
                tick();
                check($sformatf("stream_op%0d", i), 64'(b0.fpu_op_o), 64'(ops[i]));
                check($sformatf("stream_lvl%0d", i), 64'(b0.fpu_dec_level_o), 64'd1);
            end
            drive(1'b0, 5'd0, 32'h0, 32'h0);
            tick();
            check("stream_end", 64'(b0.fpu_dec_level_o), 64'd0);
        end

        // Flush at full level with a push offered, then at level 1 with a push taken
        set_ready(1'b0);
        drive(1'b1, 5'd3, 32'h3F800000, 32'h3F800000);
        repeat (2) tick();
        check("fl_pre_lvl", 64'(b0.fpu_dec_level_o), 64'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_lvl", 64'(b0.fpu_dec_level_o), 64'd0);
        check("fl_valid", 64'(b0.out_valid_o), 64'd0);
        tick();
        check("fl_refill", 64'(b0.fpu_dec_level_o), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        check("fl_push_drop", 64'(b0.fpu_dec_level_o), 64'd0);
        check("fl_push_valid", 64'(b0.out_valid_o), 64'd0);

        // Reset mid-stream
        drive(1'b1, 5'd5, 32'hFF800000, 32'hC0000000);
        repeat (2) tick();
        check("rs_pre_lvl", 64'(b0.fpu_dec_level_o), 64'd2);
        fpu_rst_n = 1'b0;
        tick();
        drive(1'b0, 5'd0, 32'h0, 32'h0);
        check("rs_valid", 64'(b0.out_valid_o), 64'd0);
        check("rs_lvl", 64'(b0.fpu_dec_level_o), 64'd0);
        check("rs_op", 64'(b0.fpu_op_o), 64'd0);
        check("rs_res", 64'(b0.fpu_res_type_o), 64'd0);
        check("rs_exp1", 64'(b0.fpu_dec_exp1_o), 64'd0);
        check("rs_sign1", 64'(b0.fpu_dec_sign1_o), 64'd0);
        fpu_rst_n = 1'b1;
        tick();
        check("rs_rdy", 64'(b0.in_ready_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_dec_q.md
# fpu_dec_q

Parametrised, streaming successor of the FPU operand decoder. Accepts an opcode and two IEEE-754 operands per valid/ready beat, then classifies both operands. It predicts special results (NaN, indeterminate, ±inf) and queues the decoded fields in a DEPTH-entry output FIFO for the arithmetic units. It sits between the AXI register front-end and the round/cast/add/sub/mult/div/comp datapaths, and replaces the enable-level handshake with full back-pressure.

## Interface
- EXPONENT_WIDTH, 8, exponent bits
- FRACTION_WIDTH, 23, stored fraction bits
- OPERAND_WIDTH, 1+EXPONENT_WIDTH+FRACTION_WIDTH, operand width (derived, not overridden)
- OPCODE_WIDTH, 5, opcode bits
- DEPTH, 2, output FIFO entries; power of two, ≥2
- NAN_MODE, 0, 0 = propagate quieted operand NaN; 1 = canonical qNaN {0, all-ones, 1, zeros}
- fpu_clk  in  1  clock
- fpu_rst_n  in  1  reset, synchronous, active-low
- fpu_dec_flush_i  in  1  synchronous FIFO clear
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when high with in_valid_i
- fpu_opcode_i  in  OPCODE_WIDTH  1=ROUND 2=CAST 3=ADD 4=SUB 5=MULT 6=DIV 7=COMP
- fpu_operand1_i, fpu_operand2_i  in  OPERAND_WIDTH  operands
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  consumer takes head
- fpu_op_o  out  7  one-hot {COMP,DIV,MULT,SUB,ADD,CAST,ROUND}
- fpu_res_type_o  out  5  one-hot {NAN,POS_INF,NEG_INF,INDET,FINITE}
- fpu_dec_sign1_o/2_o  out  1  operand signs
- fpu_dec_exp1_o/2_o  out  EXPONENT_WIDTH  raw exponents
- fpu_dec_sfgnd1_o/2_o  out  FRACTION_WIDTH+1  {hidden bit, fraction}; hidden = |exp
- fpu_dec_subnorm_o  out  2  [i-1] = operand i subnormal
- fpu_dec_invalid_o  out  1  sNaN consumed, INDET, or illegal opcode
- fpu_dec_illegal_o  out  1  opcode 0 or >7
- fpu_res_nan_o  out  OPERAND_WIDTH  NaN result (zero unless NAN type)
- fpu_dec_level_o  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Per-operand class: zero (exp=0, frac=0); subnormal (exp=0, frac≠0); normal; inf (exp all-ones, frac=0); qNaN (exp all-ones, frac MSB=1); sNaN (exp all-ones, frac MSB=0, frac≠0).
- ROUND/CAST are unary: operand2 is ignored for classification, NaN and invalid.
- Result-type priority: NAN > INDET > POS_INF > NEG_INF > FINITE.
- INDET cases:
  - ADD with opposite-sign infs.
  - SUB with same-sign infs.
  - MULT 0×inf, in either order.
  - DIV inf/inf or 0/0.
- INF cases (sign as stated):
  - ADD: either operand inf; sign of the inf.
  - SUB: op1 inf gives op1 sign; otherwise op2 inf gives inverted op2 sign.
  - MULT: either inf, neither zero; sign1^sign2.
  - DIV: op1 inf with op2 finite, or op1 finite nonzero with op2 zero; sign1^sign2.
  - ROUND/CAST: op1 inf; sign1.
- COMP: NAN or FINITE only.
- NaN, NAN_MODE=0:
  - First sNaN wins, op1 before op2, with frac MSB forced to 1.
  - Otherwise first qNaN, op1 before op2, passed unchanged.
- NaN, NAN_MODE=1: always the canonical value.
- Illegal opcode: fpu_op_o=0, res_type=NAN, canonical NaN, invalid=1, illegal=1.
- Decode is combinational on accepted inputs; the decoded entry is written to the FIFO tail.
- FIFO rules:
  - in_ready_o = level<DEPTH.
  - Push on in_valid_i&in_ready_o; pop on out_valid_o&out_ready_i.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- Output fields show the head entry and stay stable while out_valid_o&!out_ready_i. When empty, all output fields are 0.
- Flush: the level and both pointers go to 0 next edge. A push in the same cycle is discarded.

## Timing
- Reset (fpu_rst_n=0 at edge): level=0, pointers=0, out_valid_o=0, all data outputs 0. in_ready_o=1 the cycle after reset releases.
- Reset or flush mid-stream drops all queued entries; no partial beat survives.
- Latency: a beat accepted at edge N appears with out_valid_o=1 after edge N (from cycle N+1). This holds when empty, and also when the head is popped at edge N.
- Throughput: 1 beat/cycle sustained with out_ready_i=1.
- Full FIFO: in_ready_o=0. A pop at edge N makes in_ready_o=1 from N+1; in_ready_o has no combinational path from out_ready_i.
- fpu_dec_level_o is registered and equals the pushes minus pops since reset or flush.

## Structure
- Shared package fpu_pkg holds:
  - opcode constants and one-hot op bit indices;
  - res_type bit indices and the 5-bit encodings;
  - operand class encoding;
  - the canonical-NaN function of EXPONENT_WIDTH/FRACTION_WIDTH.
- Sub-module fpu_opclass: combinational per-operand classifier (zero/subnorm/normal/inf/qnan/snan, sign, hidden bit), instantiated twice.
- FIFO storage is a flat register array inside fpu_dec_q.

## Test plan
- ADD 0x7F800000, 0xFF800000 -> res_type 5'b00010, invalid=1, out_valid one cycle after acceptance.
- MULT 0xFF800000, 0xC0000000 -> res_type 5'b01000; DIV 0x3F800000, 0x80000000 -> 5'b00100.
- NAN_MODE=0, ADD 0x7F800001, 0x7FC00005 -> fpu_res_nan_o=0x7FC00001, invalid=1.
- NAN_MODE=1, same stimulus -> 0x7FC00000.
- Opcode 0 -> illegal=1, fpu_op_o=0, res_type NAN.
- DEPTH=2, out_ready_i=0, three beats offered -> level 2, in_ready_o=0, third beat held.
  - Then out_ready_i=1 -> entries emerge in order; the third beat is accepted the cycle after the first pop.
- Flush with level 2 and a simultaneous push -> level 0, out_valid_o=0 next cycle.
- Reset asserted mid-stream -> every output 0 at the next edge.
